// File: rtl/inst_axi_bridge_if.sv
// Signal bundle between the fetch stage's SRAM-like port, the bridge and the
// AXI read slave. The "master" modport is the bridge's view (it is the AXI
// master); the "slave" modport is the environment's view (fetch stage plus
// AXI slave).
//
// Handshakes: an AR transfer happens on a rising edge where arvalid & arready
// are both 1, and arvalid/araddr/arsize hold steady until that edge. An R
// transfer happens where rvalid & rready are both 1. A fetch request is taken
// in any cycle where inst_sram_addr_ok is 1, and data is delivered in any
// cycle where inst_sram_data_ok is 1.
interface inst_axi_bridge_if;
   // fetch-stage side
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   // AXI AR channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   // AXI R channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
             inst_sram_wstrb, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
             inst_sram_wstrb, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the instruction SRAM-like port to an AXI read master.
// Each accepted fetch becomes one single-beat AXI read; responses come back
// in order on a single ID and are delivered with a registered data_ok.
// Up to MAX_OUTSTANDING reads may be accepted but not yet returned.
module inst_axi_bridge #(
   parameter logic [3:0] ARID_VAL        = 4'h0,
   parameter int         MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               reset,
   inst_axi_bridge_if.master  bus,
   output logic               dbg_ar_state_o,  // 1 while an AR is waiting for arready
   output logic [1:0]         dbg_cnt_o        // accepted-but-unreturned reads
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_WAIT = 1'b1
   } ar_state_t;

   ar_state_t   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] araddr_q, araddr_d;
   logic [1:0]  arsize_q, arsize_d;
   logic        data_ok_q, data_ok_d;
   logic [31:0] rdata_q, rdata_d;
   logic        addr_ok;
   logic        r_hs;

   // The fetch stage cannot back-pressure, so R is always ready outside reset.
   assign bus.rready = ~reset;
   assign r_hs       = bus.rvalid & bus.rready;

   // Next-state logic: accept only from AR_IDLE with room in the counter,
   // hold the AR fields until arready, track outstanding reads.
   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;
      cnt_d     = cnt_q;
      data_ok_d = r_hs;
      rdata_d   = rdata_q;
      addr_ok   = 1'b0;

      case (state_q)
         AR_IDLE: begin
            addr_ok = bus.inst_sram_req & ~bus.inst_sram_wr &
                      (cnt_q < MAX_CNT) & ~reset;
            if (addr_ok) begin
               araddr_d = bus.inst_sram_addr;
               arsize_d = bus.inst_sram_size;
               state_d  = AR_WAIT;
            end
         end
         AR_WAIT: begin
            if (bus.arready) begin
               state_d = AR_IDLE;
            end
         end
         default: state_d = AR_IDLE;
      endcase

      // Simultaneous accept and return leave the count unchanged.
      if (addr_ok && !r_hs) begin
         cnt_d = cnt_q + 2'd1;
      end else if (!addr_ok && r_hs && (cnt_q != 2'd0)) begin
         cnt_d = cnt_q - 2'd1;
      end

      if (r_hs) begin
         rdata_d = bus.rdata;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= AR_IDLE;
         cnt_q     <= 2'd0;
         araddr_q  <= 32'd0;
         arsize_q  <= 2'd0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         araddr_q  <= araddr_d;
         arsize_q  <= arsize_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.inst_sram_addr_ok = addr_ok;
   assign bus.inst_sram_data_ok = data_ok_q;
   assign bus.inst_sram_rdata   = rdata_q;

   assign bus.arid    = ARID_VAL;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = 8'd0;
   assign bus.arsize  = {1'b0, arsize_q};
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.arvalid = (state_q == AR_WAIT);

   assign dbg_ar_state_o = (state_q == AR_WAIT);
   assign dbg_cnt_o      = cnt_q;

   // Write data, response ID/status and rlast carry no information here.
   logic unused_ok;
   assign unused_ok = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata,
                        bus.rid, bus.rresp, bus.rlast};

endmodule

// File: doc/inst_axi_bridge.md
# inst_axi_bridge

Read-only bridge between the IF stage's SRAM-like instruction port and an AXI3/AXI4 read master port (AR/R channels). It sits directly upstream of the fetch stage.
- It accepts fetch requests with a same-cycle `addr_ok`.
- It re-issues each accepted request as a single-beat AXI read and returns the word with a registered `data_ok`.
- It keeps up to `MAX_OUTSTANDING` reads in flight, so the fetch stage can overlap address and data phases.

## Interface
Parameters:
- `ARID_VAL`, 4'h0 — constant ID driven on `arid`. Responses return in order.
- `MAX_OUTSTANDING`, 2 — maximum accepted-but-unreturned reads, 1..3.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `inst_sram_req` in 1 — fetch request valid.
- `inst_sram_wr` in 1 — write flag; must be 0. A request with `wr`=1 is never accepted.
- `inst_sram_size` in 2 — log2 of the byte count.
- `inst_sram_addr` in 32 — physical fetch address.
- `inst_sram_wstrb` in 4 — ignored.
- `inst_sram_wdata` in 32 — ignored.
- `inst_sram_addr_ok` out 1 — request accepted this cycle.
- `inst_sram_data_ok` out 1 — `inst_sram_rdata` is valid this cycle.
- `inst_sram_rdata` out 32 — returned instruction word.
- `arid` out 4 — equals `ARID_VAL`.
- `araddr` out 32 — latched request address.
- `arlen` out 8 — 0.
- `arsize` out 3 — `{1'b0, latched size}`.
- `arburst` out 2 — 2'b01.
- `arlock` out 2 — 0.
- `arcache` out 4 — 0.
- `arprot` out 3 — 0.
- `arvalid` out 1 — AR request valid.
- `arready` in 1 — AR accepted.
- `rid` in 4 — ignored.
- `rdata` in 32 — read data.
- `rresp` in 2 — ignored.
- `rlast` in 1 — ignored; always 1 for single-beat reads.
- `rvalid` in 1 — read data valid.
- `rready` out 1 — `~reset`.

## Operation
- **AR state machine**, two states:
  - `AR_IDLE`: `arvalid`=0.
    - `inst_sram_addr_ok` = `inst_sram_req & ~inst_sram_wr & (cnt < MAX_OUTSTANDING) & ~reset`.
    - On `addr_ok`: latch `addr` into `araddr` and `size` into `arsize`, then go to `AR_WAIT`.
  - `AR_WAIT`: `arvalid`=1. `araddr` and `arsize` stay stable until handshake. `addr_ok`=0.
    - On `arvalid & arready`: go to `AR_IDLE`.
- **Outstanding counter `cnt`** (2 bits):
  - +1 on `addr_ok`.
  - −1 on an R handshake (`rvalid & rready`).
  - Both in the same cycle: unchanged.
  - Never exceeds `MAX_OUTSTANDING` and never underflows. An `rvalid` while `cnt`==0 is a protocol violation; the bench asserts it never happens.
- **R path:**
  - `rready` is held at 1; the fetch stage cannot back-pressure.
  - On an R handshake: register `rdata` into `inst_sram_rdata` and set the `data_ok` register to 1 for the next cycle only. Otherwise `data_ok` is 0 and `inst_sram_rdata` holds its last value.
- **Ordering:** responses return in request order (single ID). `data_ok` pulses map 1:1, in order, to `addr_ok` pulses.
- **Discard of unwanted returns:** the fetch stage drops stale data after a flush using its own bookkeeping. The bridge never drops or reorders data.
- **Reset:**
  - State = `AR_IDLE`, `cnt`=0, `arvalid`=0, `araddr`=0, `arsize`=0, `data_ok`=0, `rdata` register=0, `rready`=0.
  - `addr_ok` is forced to 0 during reset.
  - Reset mid-transaction abandons all in-flight reads. The system resets the AXI slave at the same time.

## Timing
- Request accepted in cycle T (`addr_ok`=1, combinational from `req`).
- `arvalid` is high from T+1 until the `arready` cycle, which is at least T+1.
- R handshake in cycle R gives `data_ok` in R+1.
- Minimum `req`-to-`data_ok` latency is 3 cycles: AR at T+1, R at T+2, `data_ok` at T+3.
- Issue rate is at most one accept per 2 cycles, because a new accept is possible only in `AR_IDLE`.
- At `cnt == MAX_OUTSTANDING`, `addr_ok` stays 0 even in `AR_IDLE`. If a response handshakes in that cycle, acceptance resumes the next cycle; there is no same-cycle bypass.
- `arvalid` never deasserts without `arready`, even if `inst_sram_req` drops.

## Test plan
- **Single fetch:** after reset, drive `req`=1, `addr`=0x1C000000, `arready`=1, and return `rdata`=0x02800C0C one cycle after AR.
  - Required: `addr_ok` at T, `arvalid` and `araddr`=0x1C000000 at T+1, `data_ok`=1 with `rdata`=0x02800C0C at T+3.
- **AR back-pressure:** hold `arready`=0 for 4 cycles while `req` toggles and `addr` changes.
  - Required: `arvalid` stays high, `araddr` is stable at the first address, and no further `addr_ok` is given.
- **Outstanding limit (`MAX`=2):** continuous `req`, `arready`=1, R withheld.
  - Required: exactly 2 `addr_ok` pulses, then `addr_ok`=0.
  - Release one R: `addr_ok` reappears the cycle after the handshake.
- **In-order return:** fetch 0x1C000000 and 0x1C000004; return 0x11111111 then 0x22222222 back-to-back.
  - Required: `data_ok` on two consecutive cycles with those values in order.
- **Write and reset:** a request with `wr`=1 gets no `addr_ok` and `arvalid` stays 0.
  - Assert `reset` while `cnt`=2 and in `AR_WAIT`.
  - Required: next cycle `arvalid`=0, `cnt`=0, `data_ok`=0, `rready`=0 while reset is high.
